transmissor_serial: RTL and testbench
=====================================

# transmissor_serial

Parallel-in, serial-out transmitter that turns a WIDTH-bit word into a bit stream, MSB first, one bit per clock. It is the transmit end of our serial register link: its `Dout_serie` and `SEL_out` drive the serial input and the shift select of a downstream shift-register receiver. After WIDTH shift edges, that receiver holds the original word. A valid/ready handshake on the parallel side lets a producer queue back-to-back words with no idle gap between frames.

## Interface
- `WIDTH`, default 4: word width in bits; legal values are 2 or more.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-low reset; sampled on the rising edge of `clk`.
- `Din` in WIDTH: parallel word to transmit.
- `load_valid` in 1: producer has a word on `Din`.
- `load_ready` out 1: transmitter can accept a word this cycle.
- `Dout_serie` out 1: serial data, MSB first.
- `SEL_out` out 1: shift enable for the receiver; 1 means `Dout_serie` carries a valid bit this cycle.
- `ultimo` out 1: high during the cycle the last bit (LSB) of a frame is on `Dout_serie`.
- `ocupado` out 1: frame in progress (equals `SEL_out`; provided for status logic).

## Operation
- Internal state:
  - `sreg[WIDTH-1:0]`: shift register.
  - `cnt`: bit counter, $clog2(WIDTH) bits.
  - FSM with two states, IDLE and SHIFT.
- **Transfer rule:** a word is accepted on a rising edge where `load_valid`=1, `load_ready`=1 and `reset`=1.
- **IDLE:**
  - Outputs: `load_ready`=1, `SEL_out`=0, `ocupado`=0, `Dout_serie`=0, `ultimo`=0.
  - On a transfer: `sreg`<=`Din`, `cnt`<=0, go to SHIFT.
- **SHIFT:**
  - Outputs: `Dout_serie`=`sreg[WIDTH-1]`, `SEL_out`=1, `ocupado`=1.
  - `ultimo`=1 and `load_ready`=1 only when `cnt`==WIDTH-1; otherwise both are 0.
  - Each edge with `cnt`<WIDTH-1: `sreg`<=`{sreg[WIDTH-2:0],1'b0}`, `cnt`<=`cnt`+1.
  - Edge with `cnt`==WIDTH-1 and a transfer: `sreg`<=`Din`, `cnt`<=0, stay in SHIFT (back-to-back frame).
  - Edge with `cnt`==WIDTH-1 and no transfer: go to IDLE, `sreg`<=0, `cnt`<=0.
- **Backpressure:** `load_valid` while `load_ready`=0 is not accepted and has no effect. The producer must hold `Din` stable until the transfer edge.
- **Word capture:** `Din` is sampled only on the transfer edge. Later changes to `Din` do not affect the frame in flight.
- **Output decoding:** all outputs decode directly from registered state (`sreg`, `cnt`, FSM). The only combinational input-to-output dependency is none: `load_ready` does not depend on `load_valid`.

## Timing
- **Reset:** `reset`=0 at an edge forces IDLE, `sreg`=0, `cnt`=0, regardless of state or `load_valid`.
  - After that edge: `Dout_serie`=0, `SEL_out`=0, `ocupado`=0, `ultimo`=0, `load_ready`=1.
  - No transfer occurs on any edge where `reset`=0.
  - Reset mid-frame aborts the frame; the remaining bits are never sent.
- **Latency:** for a word accepted at edge E0:
  - The MSB is on `Dout_serie` with `SEL_out`=1 from just after E0 until E1.
  - Bit i (from the MSB) is on the line between E(i) and E(i+1).
  - The LSB is on the line between E(WIDTH-1) and E(WIDTH), with `ultimo`=1.
- **Receiver alignment:** a receiver shifting on `SEL_out` holds the word after edge E(WIDTH).
- **Throughput:** one word per WIDTH cycles when `load_valid` is held. `SEL_out` stays high continuously across frame boundaries.
- **Gap after a frame:** if no transfer occurs at the last-bit edge, there is at least one IDLE cycle (`SEL_out`=0) before the next frame.
- **Counter range:** `cnt` never exceeds WIDTH-1.

## Test plan
- **Reset:** hold `reset`=0 for 2 cycles with `load_valid`=1 and `Din`=4'hF.
  - Required: no transfer; `SEL_out`=0, `Dout_serie`=0, `load_ready`=1 after release.
- **Single frame:** with WIDTH=4, transfer `Din`=4'b1011 at E0.
  - Required: `Dout_serie` = 1,0,1,1 over the next 4 cycles, with `SEL_out`=1 throughout.
  - Required: `ultimo`=1 only in the 4th cycle, then IDLE.
- **Back-to-back frames:** hold `load_valid`=1, presenting 4'b1011 and then 4'b0110.
  - Required: the second word is accepted at the last-bit edge of the first frame.
  - Required: the line carries 1,0,1,1,0,1,1,0 with no gap in `SEL_out` (8 consecutive 1s).
- **Backpressure:** raise `load_valid` with `Din`=4'b0001 during bit 2 of a frame carrying 4'b1100.
  - Required: `load_ready`=0 until the last-bit cycle.
  - Required: the new word is accepted at the last-bit edge; the in-flight frame is unchanged.
- **Reset mid-frame:** drive `reset`=0 after 2 bits of 4'b1010 have been sent.
  - Required: at that edge, IDLE with all outputs at their reset values; the remaining bits are never emitted.
- **Loopback:** connect a 4-bit receiver to `Dout_serie`/`SEL_out` and send 4'b1001, then 4'b0111.
  - Required: the receiver's parallel output equals 4'b1001 after E4 and 4'b0111 after E8.

Source files
------------

// File: rtl/transmissor_serial.sv
// Parallel-in, serial-out transmitter: sends a WIDTH-bit word MSB first, one bit per clock,
// with a valid/ready load port that allows back-to-back frames.
module transmissor_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] Din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             Dout_serie,
  output logic             SEL_out,
  output logic             ultimo,
  output logic             ocupado
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_bit;
  logic             xfer;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and output decode; outputs depend on registered state only
  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    cnt_d      = cnt_q;
    load_ready = 1'b0;
    Dout_serie = 1'b0;
    SEL_out    = 1'b0;
    ultimo     = 1'b0;
    last_bit   = 1'b0;
    xfer       = 1'b0;

    case (state_q)
      IDLE: begin
        load_ready = 1'b1;
        xfer       = load_valid;
        if (xfer) begin
          sreg_d  = Din;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        last_bit   = (cnt_q == CNT_LAST);
        Dout_serie = sreg_q[WIDTH-1];
        SEL_out    = 1'b1;
        ultimo     = last_bit;
        load_ready = last_bit;
        xfer       = last_bit && load_valid;
        if (!last_bit) begin
          sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
          cnt_d  = cnt_q + 1'b1;
        end else if (xfer) begin
          // Reload on the last-bit edge so SEL_out never drops between frames
          sreg_d = Din;
          cnt_d  = '0;
        end else begin
          sreg_d  = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    ocupado = SEL_out;
  end

endmodule

// File: tb/tb_transmissor_serial.sv
// Scoreboard bench for transmissor_serial: a bit-queue model predicts every cycle's outputs,
// a monitor compares them, and a loopback shift register checks received words.
module tb_transmissor_serial;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] Din = '0;
  logic         load_valid = 1'b0;
  logic         load_ready, Dout_serie, SEL_out, ultimo, ocupado;
  logic [W-1:0] rx = '0;

  typedef struct packed {
    logic sel;
    logic dout;
    logic ult;
    logic rdy;
  } exp_t;

  exp_t         expq[$];
  logic [W-1:0] exp_rx[$];
  bit           bitq[$];
  logic [W-1:0] cur_word = '0;

  int errors = 0;
  int checks = 0;

  transmissor_serial #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .Din(Din),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .Dout_serie(Dout_serie),
    .SEL_out(SEL_out),
    .ultimo(ultimo),
    .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  // Downstream receiver shifting on SEL_out
  always @(posedge clk) if (SEL_out) rx <= {rx[W-2:0], Dout_serie};

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: one expected output tuple per clock edge
  initial begin
    exp_t e;
    logic [W-1:0] w;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("SEL_out", {3'b0, SEL_out}, {3'b0, e.sel});
        check("ocupado", {3'b0, ocupado}, {3'b0, e.sel});
        check("Dout_serie", {3'b0, Dout_serie}, {3'b0, e.dout});
        check("ultimo", {3'b0, ultimo}, {3'b0, e.ult});
        check("load_ready", {3'b0, load_ready}, {3'b0, e.rdy});
      end
      if (exp_rx.size() > 0) begin
        w = exp_rx.pop_front();
        check("rx_word", rx, w);
      end
    end
  end

  // One clock of stimulus plus reference-model update
  task automatic step(input bit v, input logic [W-1:0] d, input bit r, output bit acc);
    exp_t e;
    bit   rdy_m;
    @(negedge clk);
    load_valid = v;
    Din        = d;
    reset      = r;
    @(posedge clk);
    rdy_m = (bitq.size() <= 1);
    acc   = r && v && rdy_m;
    if (!r) begin
      bitq.delete();
    end else begin
      if (bitq.size() == 1) exp_rx.push_back(cur_word);
      if (bitq.size() > 0) void'(bitq.pop_front());
      if (acc) begin
        cur_word = d;
        for (int i = W - 1; i >= 0; i--) bitq.push_back(d[i]);
      end
    end
    e.sel  = (bitq.size() > 0);
    e.dout = (bitq.size() > 0) ? bitq[0] : 1'b0;
    e.ult  = (bitq.size() == 1);
    e.rdy  = (bitq.size() <= 1);
    expq.push_back(e);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, a);
  endtask

  task automatic send_held(input logic [W-1:0] d);
    bit a;
    int n;
    a = 1'b0;
    n = 0;
    while (!a && n < 4 * W) begin
      step(1'b1, d, 1'b1, a);
      n++;
    end
    if (!a) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no transfer, expected one for %b", d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    // Reset held with a pending word
    step(1'b1, 4'hF, 1'b0, a);
    step(1'b1, 4'hF, 1'b0, a);
    idle(2);

    // Single frame
    send_held(4'b1011);
    idle(6);

    // Back-to-back frames
    send_held(4'b1011);
    send_held(4'b0110);
    idle(6);

    // Backpressure during a frame
    send_held(4'b1100);
    step(1'b0, '0, 1'b1, a);
    send_held(4'b0001);
    idle(6);

    // Reset mid-frame after two bits
    send_held(4'b1010);
    step(1'b0, '0, 1'b1, a);
    step(1'b0, '0, 1'b1, a);
    step(1'b0, '0, 1'b0, a);
    idle(6);

    // Loopback words
    send_held(4'b1001);
    send_held(4'b0111);
    idle(6);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 6), W'($urandom), ($urandom_range(0, 49) != 0), a);
    end
    idle(8);

    @(negedge clk);
    #1;
    check("expq_drained", W'(expq.size()), '0);
    check("rxq_drained", W'(exp_rx.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
